strobe_rate_bridge: RTL

- Bridges data from a slow, strobe-paced producer into a full-rate consumer using valid/ready.
- The producer's pacing strobe is the one-cycle pulse from the team's clock divider; it fires once every 8 clk cycles.
- A small circular FIFO absorbs the rate mismatch and back-pressure.
- The block sits between any divided-rate unit (e.g. slow memory or IO model) and the full-rate core pipeline.

---
 rtl/strobe_rate_bridge_pkg.sv | 20 ++
 rtl/strobe_fifo_mem.sv | 27 ++
 rtl/strobe_rate_bridge.sv | 116 +++++++++++
 3 files changed

// File: rtl/strobe_rate_bridge_pkg.sv
// Shared constants and helpers for the strobe-paced FIFO bridge.
package strobe_rate_bridge_pkg;

  localparam int DEF_DATA_W = 32;
  // Period of the divider pacing strobe, in clk cycles.
  localparam int DIV_RATIO  = 8;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/strobe_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port.
module strobe_fifo_mem
  import strobe_rate_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/strobe_rate_bridge.sv
// Strobe-paced producer to valid/ready consumer bridge over a circular FIFO.
// Optional back-to-back strobe detector enabled by STROBE_CHECK_EN.
module strobe_rate_bridge
  import strobe_rate_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_stb,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic              overflow,
  output logic [PTR_W:0]    level
`ifdef STROBE_CHECK_EN
  ,
  output logic              strobe_err
`endif
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, wr_en;

  // in_ready looks only at the pre-edge level, so a full FIFO refuses a push
  // even when the consumer pops in the same cycle.
  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign push      = in_stb & in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (PTR_W+1)'(1);
        2'b01:   level_d = level_q - (PTR_W+1)'(1);
        default: level_d = level_q;
      endcase
      if (in_stb & in_valid & ~in_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef STROBE_CHECK_EN
  logic stb_prev_q;
  logic strobe_err_q, strobe_err_d;

  always_comb begin
    strobe_err_d = strobe_err_q | (in_stb & stb_prev_q);
    if (flush) strobe_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_prev_q   <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      stb_prev_q   <= in_stb;
      strobe_err_q <= strobe_err_d;
    end
  end

  assign strobe_err = strobe_err_q;
`endif

  strobe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule
